// File: rtl/instr_fetch_stage.sv
// MIPS instruction fetch stage with IF/ID pipeline register.
// Owns the PC and drives a req/ready instruction memory port.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [15:0] id_imm16,
    output logic [31:0] id_pc_plus4
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DISCARD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_next;
    logic [31:0] inflight_addr_q, inflight_addr_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_plus4_q, skid_pc_plus4_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;

    assign pc_next     = pc_q + PC_STEP;
    assign imem_req    = (state_q == S_FETCH) || (state_q == S_DISCARD);
    // A dropped request must keep presenting its original address until it completes.
    assign imem_addr   = (state_q == S_DISCARD) ? inflight_addr_q : pc_q;
    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_imm16    = id_instr_q[15:0];
    assign id_pc_plus4 = id_pc_plus4_q;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        inflight_addr_d = inflight_addr_q;
        skid_instr_d    = skid_instr_q;
        skid_pc_plus4_d = skid_pc_plus4_q;
        id_valid_d      = stall ? id_valid_q : 1'b0;
        id_instr_d      = id_instr_q;
        id_pc_plus4_d   = id_pc_plus4_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready && !redirect) begin
                    pc_d = pc_next;
                    if (!stall || !id_valid_q) begin
                        id_valid_d    = 1'b1;
                        id_instr_d    = imem_rdata;
                        id_pc_plus4_d = pc_next;
                    end else begin
                        skid_instr_d    = imem_rdata;
                        skid_pc_plus4_d = pc_next;
                        state_d         = S_HOLD;
                    end
                end else if (redirect && !imem_ready) begin
                    inflight_addr_d = pc_q;
                    state_d         = S_DISCARD;
                end
            end
            S_HOLD: begin
                if (!stall && !redirect) begin
                    id_valid_d    = 1'b1;
                    id_instr_d    = skid_instr_q;
                    id_pc_plus4_d = skid_pc_plus4_q;
                    state_d       = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (imem_ready) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Redirect outranks stall: flush IF/ID and the skid word, retarget the PC.
        if (redirect) begin
            pc_d            = redirect_pc;
            id_valid_d      = 1'b0;
            skid_instr_d    = 32'd0;
            skid_pc_plus4_d = 32'd0;
            if (state_q == S_HOLD) begin
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            pc_q            <= RESET_PC;
            inflight_addr_q <= 32'd0;
            skid_instr_q    <= 32'd0;
            skid_pc_plus4_q <= 32'd0;
            id_valid_q      <= 1'b0;
            id_instr_q      <= 32'd0;
            id_pc_plus4_q   <= 32'd0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            inflight_addr_q <= inflight_addr_d;
            skid_instr_q    <= skid_instr_d;
            skid_pc_plus4_q <= skid_pc_plus4_d;
            id_valid_q      <= id_valid_d;
            id_instr_q      <= id_instr_d;
            id_pc_plus4_q   <= id_pc_plus4_d;
        end
    end

endmodule
